// File: rtl/clock_step_ctrl.sv
// CPU clock-enable generator: free-run with divider, N-cycle burst step, breakpoint halt.
// Breakpoint comparators and HALT exist only when CLOCK_STEP_CTRL_BREAKPOINT_EN is defined.
module clock_step_ctrl #(
  parameter int ADDR_WIDTH      = 8,
  parameter int COUNT_WIDTH     = 16,
  parameter int DIV_WIDTH       = 24,
  parameter int NUM_BREAKPOINTS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  run_en,
  input  logic                                  step_req,
  input  logic [COUNT_WIDTH-1:0]                step_count,
  input  logic [DIV_WIDTH-1:0]                  div_value,
  input  logic [NUM_BREAKPOINTS*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BREAKPOINTS-1:0]            bp_valid,
  input  logic [ADDR_WIDTH-1:0]                 address_bus,
  output logic                                  cpu_clk_en,
  output logic                                  halted,
  output logic [2:0]                            bp_hit_idx,
  output logic [1:0]                            state,
  output logic [31:0]                           cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  state_t                 state_reg, state_next;
  logic [DIV_WIDTH-1:0]   prescaler_reg, prescaler_next;
  logic [COUNT_WIDTH-1:0] remaining_reg, remaining_next;
  logic                   step_prev_reg;
  logic                   clk_en_reg, clk_en_next;
  logic                   check_reg;
  logic [2:0]             bp_idx_reg, bp_idx_next;
  logic [31:0]            cycle_count_reg;

  logic       step_rise;
  logic       active;
  logic       tick;
  logic       bp_hit;
  logic [2:0] bp_idx;

  assign step_rise = step_req & ~step_prev_reg;
  assign active    = (state_reg == ST_RUN) || (state_reg == ST_STEP);
  assign tick      = active && (prescaler_reg == div_value);

`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
  logic [NUM_BREAKPOINTS-1:0] bp_match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BREAKPOINTS; gi++) begin : g_bp
      assign bp_match[gi] = bp_valid[gi] &&
                            (bp_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] == address_bus);
    end
  endgenerate

  // Scan downwards so the lowest matching comparator is the one reported.
  always_comb begin
    bp_idx = '0;
    for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
      if (bp_match[i]) bp_idx = 3'(i);
    end
  end

  // check_reg marks the cycle after a pulse, when address_bus reflects the new fetch.
  assign bp_hit = check_reg && active && (|bp_match);
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{bp_addr, bp_valid, address_bus};
  assign bp_idx = '0;
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    clk_en_next    = 1'b0;
    bp_idx_next    = bp_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (run_en) begin
          state_next = ST_RUN;
        end else if (step_rise) begin
          state_next     = ST_STEP;
          remaining_next = (step_count == '0) ? COUNT_WIDTH'(1) : step_count;
        end
      end
      ST_RUN: begin
        if (bp_hit) begin
          state_next  = ST_HALT;
          bp_idx_next = bp_idx;
        end else if (!run_en) begin
          state_next = ST_IDLE;
        end else begin
          clk_en_next = tick;
        end
      end
      ST_STEP: begin
        // remaining counts pulses not yet scheduled; the burst ends only after
        // the last pulse has gone out and its breakpoint check has been made.
        if (bp_hit) begin
          state_next  = ST_HALT;
          bp_idx_next = bp_idx;
        end else if (remaining_reg == '0) begin
          if (check_reg && !clk_en_reg) state_next = ST_IDLE;
        end else if (tick) begin
          clk_en_next    = 1'b1;
          remaining_next = remaining_reg - COUNT_WIDTH'(1);
        end
      end
      ST_HALT: begin
        if (!run_en && step_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Prescaler restarts from zero whenever the controller enters or leaves an active mode.
  always_comb begin
    prescaler_next = '0;
    if (active && (state_next == state_reg)) begin
      prescaler_next = tick ? '0 : prescaler_reg + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      prescaler_reg   <= '0;
      remaining_reg   <= '0;
      step_prev_reg   <= 1'b1;
      clk_en_reg      <= 1'b0;
      check_reg       <= 1'b0;
      bp_idx_reg      <= '0;
      cycle_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      prescaler_reg   <= prescaler_next;
      remaining_reg   <= remaining_next;
      step_prev_reg   <= step_req;
      clk_en_reg      <= clk_en_next;
      check_reg       <= clk_en_reg;
      bp_idx_reg      <= bp_idx_next;
      cycle_count_reg <= cycle_count_reg + 32'(clk_en_reg);
    end
  end

  assign cpu_clk_en  = clk_en_reg;
  assign halted      = (state_reg == ST_HALT);
  assign bp_hit_idx  = bp_idx_reg;
  assign state       = state_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Randomised scoreboard bench for clock_step_ctrl: predicted pulse cycles are queued
// by the stimulus side and matched by a monitor against every observed cpu_clk_en.
module tb_clock_step_ctrl;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int DW = 24;
  localparam int NB = 4;
`ifdef CLOCK_STEP_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           run_en;
  logic           step_req;
  logic [CW-1:0]  step_count;
  logic [DW-1:0]  div_value;
  logic [NB*AW-1:0] bp_addr;
  logic [NB-1:0]  bp_valid;
  logic [AW-1:0]  address_bus;
  logic           cpu_clk_en;
  logic           halted;
  logic [2:0]     bp_hit_idx;
  logic [1:0]     state;
  logic [31:0]    cycle_count;

  clock_step_ctrl #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .DIV_WIDTH(DW), .NUM_BREAKPOINTS(NB)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req), .step_count(step_count),
    .div_value(div_value), .bp_addr(bp_addr), .bp_valid(bp_valid), .address_bus(address_bus),
    .cpu_clk_en(cpu_clk_en), .halted(halted), .bp_hit_idx(bp_hit_idx), .state(state),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_q[$];
  int          pl[$];
  int          mon_e;
  int          model_count = 0;
  logic [7:0]  model_addr = 8'h00;
  logic [2:0]  model_idx = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0d at cycle %0d", name, act, cyc);
    end
  endtask

  // Monitor: every enable pulse must match the next predicted pulse cycle.
  always @(negedge clk) begin
    if (cpu_clk_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          n_fail++;
          $display("FAIL pulse_cycle: got pulse at %0d expected at %0d", cyc, mon_e);
        end else begin
          $display("ok   pulse at cycle %0d addr %0h", cyc, address_bus);
        end
      end
    end
  end

  // One clock; the CPU model advances its address after each observed enable.
  task automatic next_cycle();
    logic seen;
    @(negedge clk);
    seen = cpu_clk_en;
    @(posedge clk);
    #1;
    cyc++;
    if (seen === 1'b1) address_bus = address_bus + 8'd1;
  endtask

  function automatic bit bp_lookup(input logic [7:0] a, output logic [2:0] idx);
    idx = 3'd0;
    for (int i = 0; i < NB; i++) begin
      if (bp_valid[i] && (bp_addr[i*AW +: AW] == a)) begin
        idx = 3'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Applies breakpoint rules to the pulse list: after the k-th pulse the address is a0+k+1,
  // checked one cycle later; a hit drops every pulse after that check cycle.
  task automatic model_bp(input int lim, input logic [7:0] a0, output int halt_c);
    logic [2:0] idx;
    logic [7:0] a;
    bit hit;
    halt_c = -1;
    for (int k = 0; k < pl.size(); k++) begin
      if (pl[k] + 1 > lim) break;
      a = a0 + 8'(k + 1);
      hit = bp_lookup(a, idx);
      if (BP_EN && hit) begin
        halt_c = pl[k] + 1;
        model_idx = idx;
        break;
      end
    end
    if (halt_c >= 0) begin
      while (pl.size() > 0 && pl[$] > halt_c) void'(pl.pop_back());
    end
  endtask

  task automatic commit();
    foreach (pl[i]) exp_q.push_back(pl[i]);
    model_count += pl.size();
    model_addr  += 8'(pl.size());
  endtask

  task automatic finish_txn(input bit h);
    check("state_end", 32'(state), h ? 32'd3 : 32'd0);
    check("halted", 32'(halted), 32'(h));
    check("bp_hit_idx", 32'(bp_hit_idx), 32'(model_idx));
    check("cycle_count", cycle_count, 32'(model_count));
    if (h) begin
      step_req = 1'b1;
      next_cycle();
      step_req = 1'b0;
      next_cycle();
      check("state_ack", 32'(state), 32'd0);
    end
  endtask

  // Free-run: run_en high for L cycles; ticks every d+1 cycles from the first RUN cycle.
  task automatic run_txn(input int d, input int L, input bit with_step);
    int r, halt_c;
    address_bus = model_addr;
    div_value   = DW'(d);
    run_en      = 1'b1;
    if (with_step) step_req = 1'b1;
    r = cyc;
    pl.delete();
    for (int t = r + 1 + d; t <= r + L - 1; t += d + 1) pl.push_back(t + 1);
    model_bp(r + L, model_addr, halt_c);
    commit();
    $display("txn run div=%0d len=%0d pulses=%0d halt=%0d", d, L, pl.size(), halt_c >= 0);
    for (int i = 0; i < L; i++) begin
      next_cycle();
      if (cyc == r + 1) check("state_run", 32'(state), 32'd1);
    end
    run_en   = 1'b0;
    step_req = 1'b0;
    next_cycle();
    finish_txn(halt_c >= 0);
  endtask

  // Burst: n pulses (0 means 1) spaced d+1 apart, first one d+2 cycles after the request.
  task automatic step_txn(input int d, input int n_raw);
    int s, n, last, halt_c, end_c;
    address_bus = model_addr;
    div_value   = DW'(d);
    step_count  = CW'(n_raw);
    step_req    = 1'b1;
    s = cyc;
    n = (n_raw == 0) ? 1 : n_raw;
    pl.delete();
    for (int k = 0; k < n; k++) pl.push_back(s + 2 + d + k * (d + 1));
    last = pl[$];
    model_bp(1 << 30, model_addr, halt_c);
    end_c = (halt_c >= 0) ? halt_c + 1 : last + 2;
    commit();
    $display("txn step div=%0d count=%0d pulses=%0d halt=%0d", d, n_raw, pl.size(), halt_c >= 0);
    next_cycle();
    step_req = 1'b0;
    while (cyc < end_c - 1) next_cycle();
    check("state_step", 32'(state), 32'd2);
    next_cycle();
    finish_txn(halt_c >= 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) next_cycle();
    rst = 1'b0;
    model_count = 0;
    model_idx   = 3'd0;
  endtask

  initial begin
    int s;
    rst = 1'b1; run_en = 1'b0; step_req = 1'b0; step_count = '0; div_value = '0;
    bp_addr = '0; bp_valid = '0; address_bus = 8'h00;

    // step_req held high across reset release must not start a burst
    step_req = 1'b1;
    do_reset(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bp_idx", 32'(bp_hit_idx), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_clk_en", 32'(cpu_clk_en), 32'd0);
    for (int i = 0; i < 5; i++) next_cycle();
    check("held_step_state", 32'(state), 32'd0);
    step_req = 1'b0;
    next_cycle();
    run_txn(1, 6, 1'b1);

    do_reset(2);
    run_txn(0, 10, 1'b0);
    step_txn(3, 5);
    step_txn(3, 0);

    // Breakpoint at 0x10 on comparators 1 and 2; comparator 0 matches too but is disabled
    bp_valid = 4'b0110;
    for (int i = 0; i < NB; i++) bp_addr[i*AW +: AW] = 8'h10;
    model_addr = 8'h0E;
    run_txn(3, 30, 1'b0);
    run_txn(3, 20, 1'b0);

    // Reset mid-burst: two of five pulses out, three remaining
    bp_valid = '0;
    address_bus = model_addr;
    div_value = DW'(3);
    step_count = CW'(5);
    step_req = 1'b1;
    s = cyc;
    pl.delete();
    pl.push_back(s + 5);
    pl.push_back(s + 9);
    commit();
    next_cycle();
    step_req = 1'b0;
    while (cyc < s + 10) next_cycle();
    do_reset(1);
    check("abort_state", 32'(state), 32'd0);
    check("abort_clk_en", 32'(cpu_clk_en), 32'd0);
    check("abort_cycle_count", cycle_count, 32'd0);
    next_cycle();

    for (int t = 0; t < 40; t++) begin
      bp_valid = 4'($urandom);
      for (int i = 0; i < NB; i++) bp_addr[i*AW +: AW] = model_addr + 8'($urandom_range(1, 10));
      if ($urandom_range(0, 1) == 1) run_txn($urandom_range(0, 4), $urandom_range(2, 30), 1'b0);
      else                           step_txn($urandom_range(0, 4), $urandom_range(0, 6));
    end

    next_cycle();
    check("pending_pulses", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_step_ctrl.md
Name: clock_step_ctrl

Overview:
- Parametrised successor to the board clock manager. Produces a single-cycle CPU clock-enable from the board clock, driven by probe-bus controls.
- Modes: free-run with a programmable divider, N-cycle burst step, and halt on up to NUM_BREAKPOINTS address matches.
- Sits between the PPB mapping (controls and status) and the core/RAM (clock-enable, address feedback).

Parameters:
- ADDR_WIDTH, 8, width of address_bus and each breakpoint address
- COUNT_WIDTH, 16, width of step_count and the internal remaining-steps counter
- DIV_WIDTH, 24, width of div_value and the prescaler counter
- NUM_BREAKPOINTS, 4, number of breakpoint comparators (1..8)

Ports:
- clk  input  1  board clock
- rst  input  1  synchronous reset, active-high
- run_en  input  1  level; request free-run
- step_req  input  1  level from probe; rising edge starts a burst
- step_count  input  COUNT_WIDTH  burst length; 0 is treated as 1
- div_value  input  DIV_WIDTH  enable period minus 1
- bp_addr  input  NUM_BREAKPOINTS*ADDR_WIDTH  packed breakpoint addresses; entry i is at [i*ADDR_WIDTH +: ADDR_WIDTH]
- bp_valid  input  NUM_BREAKPOINTS  per-breakpoint enable
- address_bus  input  ADDR_WIDTH  CPU address feedback
- cpu_clk_en  output  1  one-cycle enable pulse to core/RAM
- halted  output  1  high in HALT state
- bp_hit_idx  output  3  index of the breakpoint that caused the last halt
- state  output  2  IDLE=00, RUN=01, STEP=10, HALT=11
- cycle_count  output  32  number of cpu_clk_en pulses issued

Behaviour:
- Reset is synchronous and active-high and uses a single clock. On reset:
  - state=IDLE, cpu_clk_en=0, halted=0, bp_hit_idx=0, cycle_count=0.
  - Prescaler=0, remaining=0.
  - Step edge register=1, so a step_req held high through reset does not fire.
- Reset mid-burst or mid-run aborts immediately; no enable is issued in the reset cycle.
- Step edge: step_rise = step_req & ~step_prev. step_prev is registered every cycle.
- Prescaler:
  - Counts only in RUN or STEP; held at 0 otherwise.
  - tick = (prescaler == div_value). On tick the prescaler returns to 0, otherwise it increments.
  - div_value=0 gives a tick every cycle.
  - A change to div_value takes effect on the next compare. If prescaler > div_value, it continues counting and wraps at 2^DIV_WIDTH.
- cpu_clk_en is registered: high for exactly one cycle, the cycle after a tick in RUN or STEP. It is never high in IDLE or HALT, or in the cycle after a halt transition.
- State transitions (evaluated every cycle):
  - IDLE:
    - run_en=1 -> RUN (run_en has priority over step_rise in the same cycle).
    - Else step_rise -> STEP, with remaining = max(step_count,1).
  - RUN:
    - breakpoint hit -> HALT.
    - Else run_en=0 -> IDLE.
    - step_rise is ignored.
  - STEP:
    - Each issued cpu_clk_en decrements remaining.
    - When the pulse with remaining=1 is issued -> IDLE.
    - Breakpoint hit -> HALT, which wins over burst completion in the same cycle.
    - step_rise and run_en are ignored until the burst ends.
  - HALT:
    - Stays in HALT while run_en=1.
    - step_rise with run_en=0 -> IDLE (acknowledge).
- Breakpoint check:
  - Evaluated only in the cycle after a cpu_clk_en pulse, once address_bus has updated.
  - Hit = bp_valid[i] and bp_addr[i] == address_bus for any i.
  - The lowest matching index wins and is latched into bp_hit_idx. bp_hit_idx holds until the next hit or reset.
  - Resuming from HALT issues at least one pulse before the next check, so resume never re-halts on the same address.
- cycle_count increments on each cpu_clk_en and wraps 2^32-1 -> 0.
- halted = (state == HALT).

Optional Feature:
- Macro: CLOCK_STEP_CTRL_BREAKPOINT_EN.
- Defined: breakpoint comparators, bp_hit_idx latch and the HALT state behave as above.
- Undefined:
  - No comparators are generated; bp_addr, bp_valid and address_bus are ignored.
  - HALT is unreachable, halted=0, bp_hit_idx=0.
  - RUN and STEP complete normally.

Test Plan:
1. Reset, then div_value=0, run_en=1 for 10 cycles -> cpu_clk_en high on every cycle from the 2nd after run_en, state=01; run_en=0 -> state=00 next cycle, cycle_count=9.
2. div_value=3, step_count=5, pulse step_req -> exactly 5 enable pulses spaced 4 cycles apart, then state=00, cycle_count=5; step_count=0 plus a step_req pulse -> exactly 1 pulse.
3. bp_valid=4'b0110, bp_addr[1]=bp_addr[2]=8'h10, run with an address counter stimulus stepping 8'h0E->8'h10 -> state=11, halted=1, bp_hit_idx=1, no further enables; run_en=0 plus step_req -> IDLE; run_en=1 -> pulses resume with no immediate re-halt.
4. step_req held high through a reset release -> no burst starts; step_req=1 with run_en=1 in the same IDLE cycle -> RUN.
5. rst asserted mid-burst (remaining=3) -> next cycle state=00, cpu_clk_en=0, cycle_count=0; cycle_count preloaded via 2^32 pulses (forced) -> wraps to 0.
6. Macro undefined, same stimulus as scenario 3 -> run continues past 8'h10, halted stays 0.
